// File: rtl/fetch_unit_pkg.sv
// Shared core definitions: fetch FSM states, instruction size, control-flow opcodes.
// No logic; constants and types only.
// Imported by the fetch stage and its instruction buffer.
package fetch_unit_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      FULL = 2'd3
   } fetch_state_t;

   localparam int unsigned INSTR_BYTES = 4;

   // Opcodes resolved by the jump and branch unit
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

endpackage

// File: rtl/fetch_unit_buffer.sv
// One-entry instruction register between the memory response and decode.
// Latency: captured word is visible the cycle after capture_i.
// Backpressure: holds instr/pc stable until ready_i; flush_i wins over everything.
module fetch_buffer
   import fetch_unit_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            capture_i,
   input  logic            flush_i,
   input  logic            ready_i,
   input  logic [31:0]     data_i,
   input  logic [XLEN-1:0] pc_i,
   output logic            valid_o,
   output logic [31:0]     instr_o,
   output logic [XLEN-1:0] pc_o
);

   logic            valid_q, valid_d;
   logic [31:0]     instr_q, instr_d;
   logic [XLEN-1:0] pc_q, pc_d;

   // Valid bit: flush beats capture beats consumption; payload loads only on capture
   always_comb begin
      valid_d = valid_q;
      instr_d = instr_q;
      pc_d    = pc_q;
      if (flush_i) begin
         valid_d = 1'b0;
      end else if (capture_i) begin
         valid_d = 1'b1;
         instr_d = data_i;
         pc_d    = pc_i;
      end else if (valid_q && ready_i) begin
         valid_d = 1'b0;
      end
   end

   // Buffer registers
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         instr_q <= '0;
         pc_q    <= '0;
      end else begin
         valid_q <= valid_d;
         instr_q <= instr_d;
         pc_q    <= pc_d;
      end
   end

   assign valid_o = valid_q;
   assign instr_o = instr_q;
   assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, one outstanding memory request, one buffered instruction.
// Latency: rvalid at t -> instr_valid at t+1; 3 cycles per instruction with a 1-cycle memory.
// Backpressure: no new request until decode takes the buffered word; redirects drop wrong-path fetches.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int unsigned     XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [31:0]     imem_rdata,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [31:0]     instr,
   output logic [XLEN-1:0] instr_pc,
   input  logic            jack,
   input  logic            je,
   input  logic [XLEN-1:0] jump_target,
   output logic            target_misaligned
);

   localparam logic [XLEN-1:0] INSTR_STEP = XLEN'(INSTR_BYTES);

   fetch_state_t    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            drop_q, drop_d;
   logic            mis_q, mis_d;

   logic redirect;
   logic accept;
   logic capture;
   logic buf_vld;

   assign redirect = jack & je;
   assign accept   = buf_vld & instr_ready;
   // A response fills the buffer only if it is on the current path
   assign capture  = (state_q == WAIT) & imem_rvalid & ~drop_q & ~redirect;

   // State register with PC, wrong-path drop flag and misalignment pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         pc_q    <= RESET_VECTOR;
         drop_q  <= 1'b0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         drop_q  <= drop_d;
         mis_q   <= mis_d;
      end
   end

   // Next state, PC and drop flag; a redirect overrides sequential advance and decode accept
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      drop_d  = drop_q;
      mis_d   = redirect & (jump_target[1:0] != 2'b00);
      case (state_q)
         IDLE: state_d = REQ;
         REQ: begin
            if (imem_gnt) begin
               state_d = WAIT;
               // The granted request targets the old path
               if (redirect) drop_d = 1'b1;
            end
         end
         WAIT: begin
            if (imem_rvalid) begin
               // This response is either stale or consumed; no drop remains either way
               drop_d  = 1'b0;
               state_d = (drop_q | redirect) ? REQ : FULL;
            end else if (redirect) begin
               drop_d = 1'b1;
            end
         end
         FULL: begin
            if (redirect || accept) state_d = REQ;
         end
         default: state_d = IDLE;
      endcase
      if (capture)  pc_d = pc_q + INSTR_STEP;
      if (redirect) pc_d = {jump_target[XLEN-1:2], 2'b00};
   end

   // Memory port outputs derive from registered state only
   always_comb begin
      imem_req          = (state_q == REQ);
      imem_addr         = pc_q;
      target_misaligned = mis_q;
   end

   fetch_buffer #(.XLEN(XLEN)) u_buf (
      .clk       (clk),
      .rst       (rst),
      .capture_i (capture),
      .flush_i   (redirect),
      .ready_i   (instr_ready),
      .data_i    (imem_rdata),
      .pc_i      (pc_q),
      .valid_o   (buf_vld),
      .instr_o   (instr),
      .pc_o      (instr_pc)
   );

   assign instr_valid = buf_vld;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cycle table for directed cases, hand sequences for reset/wrap,
// then randomized memory/decode/redirect traffic against a program-order model.
// Outputs sampled 1 time unit after the rising edge; inputs driven at the same point.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        jack;
   logic        je;
   logic [31:0] jump_target;
   logic        target_misaligned;

   int checks = 0;
   int errors = 0;

   fetch_unit #(.XLEN(32), .RESET_VECTOR(32'h0000_0100)) dut (
      .clk               (clk),
      .rst               (rst),
      .imem_req          (imem_req),
      .imem_addr         (imem_addr),
      .imem_gnt          (imem_gnt),
      .imem_rvalid       (imem_rvalid),
      .imem_rdata        (imem_rdata),
      .instr_valid       (instr_valid),
      .instr_ready       (instr_ready),
      .instr             (instr),
      .instr_pc          (instr_pc),
      .jack              (jack),
      .je                (je),
      .jump_target       (jump_target),
      .target_misaligned (target_misaligned)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        gnt, rv;
      logic [31:0] rdata;
      logic        rdy, jk, j_e;
      logic [31:0] tgt;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_vld;
      logic [31:0] e_instr, e_pc;
      logic        e_mis;
   } vec_t;

   function automatic vec_t mk(input logic gnt, rv, input logic [31:0] rdata,
                               input logic rdy, jk, j_e, input logic [31:0] tgt,
                               input logic e_req, input logic [31:0] e_addr,
                               input logic e_vld, input logic [31:0] e_instr, e_pc,
                               input logic e_mis);
      vec_t v;
      v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.rdy = rdy; v.jk = jk; v.j_e = j_e;
      v.tgt = tgt; v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld;
      v.e_instr = e_instr; v.e_pc = e_pc; v.e_mis = e_mis;
      return v;
   endfunction

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
      instr_ready = 1'b0; jack = 1'b0; je = 1'b0; jump_target = '0;
   endtask

   task automatic chk_reset(input string nm);
      chk({nm, "_req"},  imem_req, 0);
      chk({nm, "_addr"}, imem_addr, 32'h100);
      chk({nm, "_vld"},  instr_valid, 0);
      chk({nm, "_instr"}, instr, 0);
      chk({nm, "_pc"},   instr_pc, 0);
      chk({nm, "_mis"},  target_misaligned, 0);
   endtask

   vec_t vt[23];

   logic [31:0] exp_pc, raddr, p_addr;
   logic        pend, p_req, p_gnt, p_redir, p_mis, redir, s_req;
   int          due, accepts;

   initial begin
      // cycle-by-cycle table, starting in IDLE right after reset release
      //            gnt rv rdata         rdy jk je tgt        | req addr        vld instr         pc            mis
      vt[0]  = mk(0, 0, 32'h0,        0, 0, 0, 32'h0,      0, 32'h0,   0, 32'h0,        32'h0,   0);
      vt[1]  = mk(1, 0, 32'h0,        0, 0, 0, 32'h0,      1, 32'h100, 0, 32'h0,        32'h0,   0);
      vt[2]  = mk(0, 1, 32'h13,       0, 0, 0, 32'h0,      0, 32'h0,   0, 32'h0,        32'h0,   0);
      for (int i = 3; i < 8; i++)
         vt[i] = mk(0, 0, 32'h0,      0, 0, 0, 32'h0,      0, 32'h0,   1, 32'h13,       32'h100, 0);
      vt[8]  = mk(0, 0, 32'h0,        1, 0, 0, 32'h0,      0, 32'h0,   1, 32'h13,       32'h100, 0);
      vt[9]  = mk(1, 0, 32'h0,        0, 0, 0, 32'h0,      1, 32'h104, 0, 32'h0,        32'h0,   0);
      vt[10] = mk(0, 0, 32'h0,        0, 1, 1, 32'h200,    0, 32'h0,   0, 32'h0,        32'h0,   0);
      vt[11] = mk(0, 1, 32'hDEADBEEF, 0, 0, 0, 32'h0,      0, 32'h0,   0, 32'h0,        32'h0,   0);
      vt[12] = mk(1, 0, 32'h0,        0, 0, 0, 32'h0,      1, 32'h200, 0, 32'h0,        32'h0,   0);
      vt[13] = mk(0, 1, 32'h11111111, 0, 1, 1, 32'h300,    0, 32'h0,   0, 32'h0,        32'h0,   0);
      vt[14] = mk(1, 0, 32'h0,        0, 0, 0, 32'h0,      1, 32'h300, 0, 32'h0,        32'h0,   0);
      vt[15] = mk(0, 1, 32'h22222222, 0, 0, 0, 32'h0,      0, 32'h0,   0, 32'h0,        32'h0,   0);
      vt[16] = mk(0, 0, 32'h0,        1, 1, 0, 32'h500,    0, 32'h0,   1, 32'h22222222, 32'h300, 0);
      vt[17] = mk(0, 0, 32'h0,        0, 1, 1, 32'h203,    1, 32'h304, 0, 32'h0,        32'h0,   0);
      vt[18] = mk(1, 0, 32'h0,        0, 0, 0, 32'h0,      1, 32'h200, 0, 32'h0,        32'h0,   1);
      vt[19] = mk(0, 1, 32'h33333333, 0, 0, 0, 32'h0,      0, 32'h0,   0, 32'h0,        32'h0,   0);
      vt[20] = mk(0, 0, 32'h0,        1, 1, 1, 32'h400,    0, 32'h0,   1, 32'h33333333, 32'h200, 0);
      vt[21] = mk(0, 0, 32'h0,        0, 0, 0, 32'h0,      1, 32'h400, 0, 32'h0,        32'h0,   0);
      vt[22] = mk(0, 0, 32'h0,        0, 0, 0, 32'h0,      1, 32'h400, 0, 32'h0,        32'h0,   0);

      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      chk_reset("reset");
      rst = 1'b0;

      for (int i = 0; i < 23; i++) begin
         chk($sformatf("t%0d_req", i), imem_req, vt[i].e_req);
         if (vt[i].e_req) chk($sformatf("t%0d_addr", i), imem_addr, vt[i].e_addr);
         chk($sformatf("t%0d_vld", i), instr_valid, vt[i].e_vld);
         if (vt[i].e_vld) begin
            chk($sformatf("t%0d_instr", i), instr, vt[i].e_instr);
            chk($sformatf("t%0d_pc", i), instr_pc, vt[i].e_pc);
         end
         chk($sformatf("t%0d_mis", i), target_misaligned, vt[i].e_mis);
         imem_gnt = vt[i].gnt; imem_rvalid = vt[i].rv; imem_rdata = vt[i].rdata;
         instr_ready = vt[i].rdy; jack = vt[i].jk; je = vt[i].j_e; jump_target = vt[i].tgt;
         tick();
      end

      // reset while a request is outstanding
      idle_inputs();
      imem_gnt = 1'b1;
      tick();
      idle_inputs();
      rst = 1'b1;
      tick();
      chk_reset("midrst");
      rst = 1'b0;
      tick();
      chk("midrst_restart_req", imem_req, 1);
      chk("midrst_restart_addr", imem_addr, 32'h100);

      // PC wrap from the last word to address zero
      jack = 1'b1; je = 1'b1; jump_target = 32'hFFFF_FFFC;
      tick();
      idle_inputs();
      chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
      imem_gnt = 1'b1;
      tick();
      idle_inputs();
      imem_rvalid = 1'b1; imem_rdata = 32'hCAFE_0001;
      tick();
      idle_inputs();
      chk("wrap_vld", instr_valid, 1);
      chk("wrap_pc", instr_pc, 32'hFFFF_FFFC);
      instr_ready = 1'b1;
      tick();
      idle_inputs();
      chk("wrap_req", imem_req, 1);
      chk("wrap_next_addr", imem_addr, 32'h0);

      // randomized traffic against program-order model
      exp_pc = 32'h0; pend = 1'b0; due = 0; raddr = '0; accepts = 0;
      p_req = 1'b0; p_gnt = 1'b0; p_redir = 1'b0; p_mis = 1'b0; p_addr = '0;
      for (int c = 0; c < 3000; c++) begin
         s_req = imem_req;
         if (s_req) begin
            chk("rnd_addr", imem_addr, exp_pc);
            if (p_req && !p_gnt && !p_redir) chk("rnd_addr_stable", imem_addr, p_addr);
         end
         if (p_redir) chk("rnd_flush", instr_valid, 0);
         chk("rnd_mis", target_misaligned, p_mis);
         if (instr_valid) begin
            chk("rnd_pc", instr_pc, exp_pc);
            chk("rnd_instr", instr, mem_word(exp_pc));
         end

         imem_gnt    = s_req && !pend && ($urandom_range(0, 2) != 0);
         imem_rvalid = pend && (c >= due);
         imem_rdata  = imem_rvalid ? mem_word(raddr) : $urandom;
         instr_ready = ($urandom_range(0, 9) < 7);
         jack        = ($urandom_range(0, 9) == 0);
         je          = $urandom_range(0, 1) != 0;
         case ($urandom_range(0, 3))
            0:       jump_target = $urandom;
            1:       jump_target = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            default: jump_target = 32'($urandom_range(0, 4095));
         endcase

         if (instr_valid && instr_ready) begin
            exp_pc = exp_pc + 32'd4;
            accepts++;
         end
         redir = jack && je;
         if (redir) exp_pc = {jump_target[31:2], 2'b00};
         if (imem_rvalid) pend = 1'b0;
         if (imem_gnt) begin
            pend  = 1'b1;
            due   = c + $urandom_range(1, 3);
            raddr = imem_addr;
         end
         p_req = s_req; p_gnt = imem_gnt; p_redir = redir; p_addr = imem_addr;
         p_mis = redir && (jump_target[1:0] != 2'b00);
         tick();
      end
      chk("rnd_progress", (accepts > 100) ? 1 : 0, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage. It owns the program counter, fetches one 32-bit instruction at a time over a request/grant/response memory port, and hands instructions to decode with a valid/ready handshake. It consumes the `jack`/`je` resolution produced by the jump and branch unit, together with the computed target, to redirect the PC. It also discards any wrong-path fetch that is already in flight.

## Interface
- `XLEN`, 32, PC and address width.
- `RESET_VECTOR`, `'0`, first fetch address after reset; bits [1:0] must be 0.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `imem_req` out 1: fetch request valid.
- `imem_addr` out XLEN: fetch byte address, word aligned.
- `imem_gnt` in 1: request accepted this cycle when `imem_req & imem_gnt`.
- `imem_rvalid` in 1: response valid; one response per granted request, in order, at least 1 cycle after the grant.
- `imem_rdata` in 32: instruction word.
- `instr_valid` out 1: instruction available to decode.
- `instr_ready` in 1: decode accepts when `instr_valid & instr_ready`.
- `instr` out 32: fetched instruction.
- `instr_pc` out XLEN: address of `instr`.
- `jack` in 1: control-flow instruction resolved this cycle.
- `je` in 1: resolved instruction is taken.
- `jump_target` in XLEN: taken target; sampled only when `jack & je`.
- `target_misaligned` out 1: one-cycle pulse when a taken target has bits [1:0] != 0.

## Operation
- The unit has a single outstanding request. It holds a one-entry instruction buffer (`instr`, `instr_pc`, valid bit) and a `drop` flag.
- FSM states:
  - IDLE: entered on reset.
  - REQ: `imem_req` = 1.
  - WAIT: granted, awaiting `imem_rvalid`.
  - FULL: response buffered, no request outstanding.
- Transitions:
  - IDLE→REQ: unconditional, on the first cycle after `rst` deasserts.
  - REQ→WAIT: on grant.
  - WAIT→FULL: on `imem_rvalid` with `drop` = 0. The buffer captures `imem_rdata` and the PC of the request, and `pc` advances by 4.
  - WAIT→REQ: on `imem_rvalid` with `drop` = 1. The response is discarded and `drop` clears.
  - FULL→REQ: when decode accepts the buffered instruction.
- Redirect is taken when `jack & je`:
  - `pc` <= `{jump_target[XLEN-1:2], 2'b00}`.
  - The buffer valid bit clears.
  - `target_misaligned` pulses if `jump_target[1:0]` != 0. The fetch still proceeds to the aligned address.
- Redirect handling per state:
  - REQ without grant: stay in REQ; `imem_addr` shows the new PC from the next cycle.
  - REQ with grant, or WAIT: `drop` sets. If `imem_rvalid` arrives in the same cycle, that response is discarded instead of setting `drop`.
  - FULL: go to REQ.
- A `jack` with `je` = 0 has no effect.
- PC arithmetic is modulo 2^XLEN: `pc` + 4 wraps from `'1` & ~3 to 0.
- Redirect has priority over a decode accept in the same cycle. The instruction is still counted as consumed, but no new buffer fill occurs from it.

## Timing
- Reset values:
  - `imem_req` = 0, `imem_addr` = `RESET_VECTOR`.
  - `instr_valid` = 0, `instr` = 0, `instr_pc` = 0.
  - `target_misaligned` = 0, `drop` = 0, `pc` = `RESET_VECTOR`.
- `rst` asserted mid-operation returns to IDLE on the next edge and ignores any response still in flight. The memory is reset in the same cycle.
- Fetch latency:
  - `imem_rvalid` at cycle t → `instr_valid` at t+1.
  - Next `imem_req` at the cycle after the buffer is accepted.
  - Peak throughput is 1 instruction per 3 cycles with a 1-cycle memory.
- While `imem_req` = 1 and not granted, `imem_addr` is stable except on redirect.
- `instr_valid` drops in the cycle after a redirect. It never presents a wrong-path instruction after that point.
- `instr`/`instr_pc` hold stable while `instr_valid & !instr_ready`.

## Structure
- Shared core package holds:
  - the FSM state enum `fetch_state_t` (IDLE, REQ, WAIT, FULL);
  - the `INSTR_BYTES` = 4 constant;
  - the opcode constants already used by the jump and branch unit.
- One natural sub-module: `fetch_buffer`, the one-entry instruction register with valid/ready, flush and capture.

## Test plan
- Reset release, `RESET_VECTOR` = 0x100, grant immediate, 1-cycle response 0x00000013 → `instr_valid` with `instr` = 0x00000013 and `instr_pc` = 0x100; next request at 0x104.
- `instr_ready` held low 5 cycles → `instr`/`instr_pc` stable and no new `imem_req`; ready high → request to next PC the following cycle.
- Redirect (`jack` = `je` = 1, `jump_target` = 0x200) while in WAIT → the in-flight response is never presented; next `imem_addr` = 0x200.
- Redirect in the same cycle as `imem_rvalid` → that response is dropped; next request at target.
- `jack` = 1, `je` = 0 → no change to PC or buffer; sequential fetch continues.
- `jump_target` = 0x203 → `target_misaligned` pulses for 1 cycle; fetch issued at 0x200.
